param_dcache: RTL

PARAM_DCACHE -- requirements
Module: param_dcache

---
 rtl/param_dcache.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/param_dcache.sv
// param_dcache: write-back, write-allocate set-associative data cache.
// Register-array storage, pseudo-LRU replacement, one-hot control FSM.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cpu_req_i/op_i/...    CPU request (op 1 = store), byte mask, data
//   cpu_rd_data_o         load data, valid with cpu_data_ack_o
//   cpu_addr_ack_o        request accepted this cycle
//   cpu_data_ack_o        one-cycle completion pulse per request
//   ram_rd_*              line-fill request and word stream
//   ram_wr_*              dirty victim write-back (whole line)
//   hit_cnt_o/miss_cnt_o  lookup counters
//
// Macro DCACHE_PERF_CNT_EN: when defined, hit/miss counters are built;
// otherwise both counter ports are tied to 0.
module param_dcache #(
  parameter int WAY_NUM    = 2,
  parameter int SET_NUM    = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_i,
  input  logic                    cpu_op_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [3:0]              cpu_wr_en_i,
  input  logic [31:0]             cpu_wr_data_i,
  output logic [31:0]             cpu_rd_data_o,
  output logic                    cpu_addr_ack_o,
  output logic                    cpu_data_ack_o,
  output logic                    ram_rd_req_o,
  output logic [31:0]             ram_rd_addr_o,
  input  logic                    ram_rd_rdy_i,
  input  logic [31:0]             ram_rd_data_i,
  input  logic                    ram_rd_valid_i,
  input  logic                    ram_rd_last_i,
  output logic                    ram_wr_req_o,
  output logic [31:0]             ram_wr_addr_o,
  output logic [32*LINE_WORDS-1:0] ram_wr_data_o,
  input  logic                    ram_wr_rdy_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SET_NUM);
  localparam int TB = 32 - IB - WB - 2;
  localparam int WW = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int PW = (WAY_NUM == 4) ? 3 : 1;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LOOKUP  = 5'b00010,
    MISS    = 5'b00100,
    REPLACE = 5'b01000,
    REFILL  = 5'b10000
  } state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          op_q;
  logic [WB-1:0] cnt_q;
  logic [WW-1:0] vic_q;
  logic          wb_q;

  logic [WAY_NUM-1:0] valid_q [SET_NUM];
  logic [WAY_NUM-1:0] dirty_q [SET_NUM];
  logic [PW-1:0]      plru_q  [SET_NUM];
  logic [TB-1:0]      tag_q   [WAY_NUM][SET_NUM];
  logic [31:0]        data_q  [WAY_NUM][SET_NUM][LINE_WORDS];

  logic [TB-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic [WB-1:0] req_word;
  logic          unused_lsb;

  assign req_tag    = addr_q[31 -: TB];
  assign req_idx    = addr_q[2+WB +: IB];
  assign req_word   = addr_q[2 +: WB];
  assign unused_lsb = ^addr_q[1:0];

  function automatic logic [31:0] merge(
    input logic [31:0] od,
    input logic [31:0] nd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? nd[8*b +: 8] : od[8*b +: 8];
    return r;
  endfunction

  logic [WAY_NUM-1:0] hit_vec;
  logic               hit;
  logic [WW-1:0]      hit_way;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      hit_vec[w] = valid_q[req_idx][w] &&
                   (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
  end

  assign hit = |hit_vec;

  logic          inv_any;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] plru_way;
  logic [WW-1:0] vic_way;
  logic [WW-1:0] upd_way;
  logic [PW-1:0] plru_cur;
  logic [PW-1:0] plru_nxt;

  // Scan downwards so the lowest-index invalid way wins.
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign vic_way  = inv_any ? inv_way : plru_way;
  assign plru_cur = plru_q[req_idx];

  // PLRU bits point at the least-recently-used side.
  generate
    if (WAY_NUM == 4) begin : g_plru4
      assign plru_way = plru_cur[0] ? {1'b1, plru_cur[2]}
                                    : {1'b0, plru_cur[1]};
      always_comb begin
        plru_nxt    = plru_cur;
        plru_nxt[0] = ~upd_way[1];
        if (upd_way[1]) plru_nxt[2] = ~upd_way[0];
        else            plru_nxt[1] = ~upd_way[0];
      end
    end else if (WAY_NUM == 2) begin : g_plru2
      assign plru_way = plru_cur;
      assign plru_nxt = ~upd_way;
    end else begin : g_plru1
      assign plru_way = '0;
      assign plru_nxt = plru_cur;
    end
  endgenerate

  logic        lookup_hit;
  logic        fill_beat;
  logic        fill_done;
  logic [31:0] hit_word;
  logic [31:0] fill_word;

  assign lookup_hit = (state_q == LOOKUP) && hit;
  assign fill_beat  = (state_q == REFILL) && ram_rd_valid_i;
  assign fill_done  = fill_beat && ram_rd_last_i;
  assign upd_way    = (state_q == REFILL) ? vic_q : hit_way;
  assign hit_word   = data_q[hit_way][req_idx][req_word];
  assign fill_word  = (op_q && cnt_q == req_word)
                    ? merge(ram_rd_data_i, wdata_q, be_q)
                    : ram_rd_data_i;

  assign cpu_addr_ack_o = rst_n && cpu_req_i &&
                          ((state_q == IDLE) || lookup_hit);
  assign cpu_data_ack_o = lookup_hit || fill_done;

  // The requested word may be the one arriving right now.
  always_comb begin
    cpu_rd_data_o = '0;
    if (lookup_hit)
      cpu_rd_data_o = hit_word;
    else if (fill_done)
      cpu_rd_data_o = (cnt_q == req_word) ? fill_word
                    : data_q[vic_q][req_idx][req_word];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      vic_q   <= '0;
      wb_q    <= 1'b0;
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (cpu_addr_ack_o) begin
        addr_q  <= cpu_addr_i;
        op_q    <= cpu_op_i;
        be_q    <= cpu_wr_en_i;
        wdata_q <= cpu_wr_data_i;
      end
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (op_q) dirty_q[req_idx][hit_way] <= 1'b1;
            plru_q[req_idx] <= plru_nxt;
            if (!cpu_req_i) state_q <= IDLE;
          end else begin
            vic_q   <= vic_way;
            wb_q    <= valid_q[req_idx][vic_way] &&
                       dirty_q[req_idx][vic_way];
            state_q <= MISS;
          end
        end
        MISS: begin
          if (!wb_q || ram_wr_rdy_i) state_q <= REPLACE;
        end
        REPLACE: begin
          if (ram_rd_rdy_i) state_q <= REFILL;
        end
        REFILL: begin
          if (ram_rd_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (ram_rd_last_i) begin
              cnt_q                   <= '0;
              valid_q[req_idx][vic_q] <= 1'b1;
              dirty_q[req_idx][vic_q] <= op_q;
              plru_q[req_idx]         <= plru_nxt;
              state_q                 <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (lookup_hit && op_q)
      data_q[hit_way][req_idx][req_word] <=
        merge(hit_word, wdata_q, be_q);
    if (fill_beat)
      data_q[vic_q][req_idx][cnt_q] <= fill_word;
    if (fill_done)
      tag_q[vic_q][req_idx] <= req_tag;
  end

  assign ram_wr_req_o  = (state_q == MISS) && wb_q;
  assign ram_wr_addr_o = ram_wr_req_o
    ? {tag_q[vic_q][req_idx], req_idx, {(WB+2){1'b0}}} : '0;

  always_comb begin
    ram_wr_data_o = '0;
    if (ram_wr_req_o)
      for (int w = 0; w < LINE_WORDS; w++)
        ram_wr_data_o[32*w +: 32] = data_q[vic_q][req_idx][w];
  end

  assign ram_rd_req_o  = (state_q == REPLACE);
  assign ram_rd_addr_o = ram_rd_req_o
    ? {req_tag, req_idx, {(WB+2){1'b0}}} : '0;

`ifdef DCACHE_PERF_CNT_EN
  logic        lookup_miss;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign lookup_miss = (state_q == LOOKUP) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule
